// File: rtl/msi_cache_ctrl.sv
// Direct-mapped write-back L1 controller with MSI snooping; one CPU port, one shared bus.
// All outputs registered (decision at cycle t visible at t+1); snoops take priority and stall the CPU-side FSM.
module msi_cache_ctrl #(
  parameter int ADDR_W = 3,
  parameter int DATA_W = 4,
  parameter int LINES  = 2
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              cpu_req,
  input  logic              cpu_write,
  input  logic [ADDR_W-1:0] cpu_address,
  input  logic [DATA_W-1:0] cpu_data_in,
  output logic              cpu_done,
  output logic [DATA_W-1:0] cpu_data_out,
  output logic              bus_read_miss,
  output logic              bus_write_miss,
  output logic              bus_invalidate,
  output logic              bus_write_back,
  output logic [ADDR_W-1:0] bus_address,
  output logic [DATA_W-1:0] bus_data_out,
  input  logic              fill_valid,
  input  logic [DATA_W-1:0] fill_data,
  input  logic              snoop_valid,
  input  logic [1:0]        snoop_type,
  input  logic [ADDR_W-1:0] snoop_address
);
  localparam int IDX_W = $clog2(LINES);
  localparam int TAG_W = ADDR_W - IDX_W;
  localparam logic [1:0] ST_I = 2'b00;
  localparam logic [1:0] ST_S = 2'b01;
  localparam logic [1:0] ST_M = 2'b10;

  typedef enum logic [2:0] {IDLE, LOOKUP, WB, ISSUE, FILL} fsm_t;

  fsm_t              r_fsm;
  logic              r_write;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_wdata;
  logic [1:0]        r_state [LINES];
  logic [TAG_W-1:0]  r_tag   [LINES];
  logic [DATA_W-1:0] r_data  [LINES];

  logic [IDX_W-1:0]  w_ridx, w_sidx;
  logic [TAG_W-1:0]  w_rtag, w_stag;
  logic              w_req_hit, w_snoop_hit, w_snoop_flush, w_stall;

  assign w_ridx = r_addr[IDX_W-1:0];
  assign w_rtag = r_addr[ADDR_W-1:IDX_W];
  assign w_sidx = snoop_address[IDX_W-1:0];
  assign w_stag = snoop_address[ADDR_W-1:IDX_W];

  assign w_req_hit     = (r_state[w_ridx] != ST_I) && (r_tag[w_ridx] == w_rtag);
  assign w_snoop_hit   = snoop_valid && (snoop_type != 2'b11) &&
                         (r_state[w_sidx] != ST_I) && (r_tag[w_sidx] == w_stag);
  assign w_snoop_flush = w_snoop_hit && (r_state[w_sidx] == ST_M) && !snoop_type[1];
  // ISSUE only yields when a snoop flush would collide with its bus pulse.
  assign w_stall = (((r_fsm == LOOKUP) || (r_fsm == WB)) && w_snoop_hit) ||
                   ((r_fsm == ISSUE) && w_snoop_flush);

  always_ff @(posedge clock) begin
    if (reset) begin
      r_fsm          <= IDLE;
      r_write        <= 1'b0;
      r_addr         <= '0;
      r_wdata        <= '0;
      cpu_done       <= 1'b0;
      cpu_data_out   <= '0;
      bus_read_miss  <= 1'b0;
      bus_write_miss <= 1'b0;
      bus_invalidate <= 1'b0;
      bus_write_back <= 1'b0;
      bus_address    <= '0;
      bus_data_out   <= '0;
      for (int i = 0; i < LINES; i++) begin
        r_state[i] <= ST_I;
        r_tag[i]   <= '0;
        r_data[i]  <= '0;
      end
    end else begin
      cpu_done       <= 1'b0;
      bus_read_miss  <= 1'b0;
      bus_write_miss <= 1'b0;
      bus_invalidate <= 1'b0;
      bus_write_back <= 1'b0;

      if (w_snoop_hit) begin
        if (w_snoop_flush) begin
          bus_write_back <= 1'b1;
          bus_address    <= snoop_address;
          bus_data_out   <= r_data[w_sidx];
        end
        r_state[w_sidx] <= (snoop_type == 2'b00) ? ST_S : ST_I;
        if ((snoop_type == 2'b00) && (r_state[w_sidx] == ST_S))
          r_state[w_sidx] <= ST_S;
      end

      case (r_fsm)
        IDLE: if (cpu_req) begin
          r_write <= cpu_write;
          r_addr  <= cpu_address;
          r_wdata <= cpu_data_in;
          r_fsm   <= LOOKUP;
        end
        LOOKUP: if (!w_stall) begin
          if (w_req_hit) begin
            cpu_done <= 1'b1;
            r_fsm    <= IDLE;
            if (!r_write) begin
              cpu_data_out <= r_data[w_ridx];
            end else begin
              r_data[w_ridx]  <= r_wdata;
              r_state[w_ridx] <= ST_M;
              if (r_state[w_ridx] == ST_S) begin
                bus_invalidate <= 1'b1;
                bus_address    <= r_addr;
              end
            end
          end else begin
            r_fsm <= (r_state[w_ridx] == ST_M) ? WB : ISSUE;
          end
        end
        WB: if (!w_stall) begin
          // A stalling snoop may already have demoted the victim; flush only if still dirty.
          if (r_state[w_ridx] == ST_M) begin
            bus_write_back  <= 1'b1;
            bus_address     <= {r_tag[w_ridx], w_ridx};
            bus_data_out    <= r_data[w_ridx];
            r_state[w_ridx] <= ST_I;
          end
          r_fsm <= ISSUE;
        end
        ISSUE: if (!w_stall) begin
          bus_read_miss  <= !r_write;
          bus_write_miss <= r_write;
          bus_address    <= r_addr;
          r_fsm          <= FILL;
        end
        FILL: if (fill_valid) begin
          r_tag[w_ridx] <= w_rtag;
          cpu_done      <= 1'b1;
          r_fsm         <= IDLE;
          if (r_write) begin
            r_state[w_ridx] <= ST_M;
            r_data[w_ridx]  <= r_wdata;
          end else begin
            r_state[w_ridx] <= ST_S;
            r_data[w_ridx]  <= fill_data;
            cpu_data_out    <= fill_data;
          end
        end
        default: r_fsm <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_msi_cache_ctrl.sv
// Directed bench for msi_cache_ctrl: stimulus pushes expected bus/CPU events, a negedge monitor pops and compares.
module tb_msi_cache_ctrl;
  localparam int K_DONE = 0, K_RM = 1, K_WM = 2, K_INV = 3, K_WB = 4;

  typedef struct {
    int         kind;
    int         cyc;
    logic [2:0] addr;
    logic [3:0] data;
  } ev_t;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       cpu_req = 1'b0, cpu_write = 1'b0;
  logic [2:0] cpu_address = '0;
  logic [3:0] cpu_data_in = '0;
  logic       cpu_done;
  logic [3:0] cpu_data_out;
  logic       bus_read_miss, bus_write_miss, bus_invalidate, bus_write_back;
  logic [2:0] bus_address;
  logic [3:0] bus_data_out;
  logic       fill_valid = 1'b0;
  logic [3:0] fill_data = '0;
  logic       snoop_valid = 1'b0;
  logic [1:0] snoop_type = '0;
  logic [2:0] snoop_address = '0;

  int  cyc = 0;
  int  t0 = 0;
  int  total = 0;
  int  bad = 0;
  ev_t q[$];

  msi_cache_ctrl #(.ADDR_W(3), .DATA_W(4), .LINES(2)) dut (
    .clock(clock), .reset(reset),
    .cpu_req(cpu_req), .cpu_write(cpu_write), .cpu_address(cpu_address),
    .cpu_data_in(cpu_data_in), .cpu_done(cpu_done), .cpu_data_out(cpu_data_out),
    .bus_read_miss(bus_read_miss), .bus_write_miss(bus_write_miss),
    .bus_invalidate(bus_invalidate), .bus_write_back(bus_write_back),
    .bus_address(bus_address), .bus_data_out(bus_data_out),
    .fill_valid(fill_valid), .fill_data(fill_data),
    .snoop_valid(snoop_valid), .snoop_type(snoop_type), .snoop_address(snoop_address)
  );

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  task automatic push(input int kind, input int c, input logic [2:0] a, input logic [3:0] d);
    ev_t e;
    e.kind = kind; e.cyc = c; e.addr = a; e.data = d;
    q.push_back(e);
  endtask

  task automatic chk_ev(input int kind, input logic [2:0] a, input logic [3:0] d);
    ev_t e;
    total++;
    if (q.size() == 0) begin
      bad++;
      $display("FAIL unexpected_event kind=%0d cyc=%0d addr=%b data=%h (nothing expected)", kind, cyc, a, d);
    end else begin
      e = q.pop_front();
      if (e.kind != kind || e.cyc != cyc ||
          ((kind != K_DONE) && (e.addr != a)) ||
          ((kind == K_DONE || kind == K_WB) && (e.data != d))) begin
        bad++;
        $display("FAIL event got kind=%0d cyc=%0d addr=%b data=%h, want kind=%0d cyc=%0d addr=%b data=%h",
                 kind, cyc, a, d, e.kind, e.cyc, e.addr, e.data);
      end
    end
  endtask

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%h want=%h", name, act, exp);
    end
  endtask

  // Monitor: every asserted pulse is one scoreboard event, in a fixed per-cycle order.
  always @(negedge clock) begin
    if (bus_write_back) chk_ev(K_WB, bus_address, bus_data_out);
    if (bus_invalidate) chk_ev(K_INV, bus_address, bus_data_out);
    if (bus_read_miss)  chk_ev(K_RM, bus_address, bus_data_out);
    if (bus_write_miss) chk_ev(K_WM, bus_address, bus_data_out);
    if (cpu_done)       chk_ev(K_DONE, bus_address, cpu_data_out);
    if (int'(bus_write_back) + int'(bus_invalidate) + int'(bus_read_miss) + int'(bus_write_miss) > 1)
      chk("bus_exclusive", 8'd1, 8'd0);
  end

  task automatic start_req(input logic w, input logic [2:0] a, input logic [3:0] d);
    @(posedge clock); #1;
    cpu_req = 1'b1; cpu_write = w; cpu_address = a; cpu_data_in = d;
    t0 = cyc;
  endtask

  // Holds the request until cpu_done; answers any miss pulse with a fill one cycle later.
  task automatic wait_done(input logic [3:0] fdat, input logic [3:0] fill_exp,
                           input int snoop_off, input logic [1:0] st, input logic [2:0] sa);
    bit done = 0;
    for (int i = 0; i < 60 && !done; i++) begin
      @(posedge clock); #1;
      fill_valid = 1'b0;
      snoop_valid = 1'b0;
      if (cyc == t0 + snoop_off) begin
        snoop_valid = 1'b1; snoop_type = st; snoop_address = sa;
      end
      if (cpu_done) begin
        cpu_req = 1'b0;
        done = 1;
      end else if (bus_read_miss || bus_write_miss) begin
        fill_valid = 1'b1; fill_data = fdat;
        push(K_DONE, cyc + 1, 3'b000, fill_exp);
      end
    end
    if (!done) begin
      cpu_req = 1'b0;
      chk("cpu_done_timeout", 8'd0, 8'd1);
    end
  endtask

  task automatic do_snoop(input logic [1:0] st, input logic [2:0] sa, input bit flush, input logic [3:0] d);
    @(posedge clock); #1;
    snoop_valid = 1'b1; snoop_type = st; snoop_address = sa;
    if (flush) push(K_WB, cyc + 1, sa, d);
    @(posedge clock); #1;
    snoop_valid = 1'b0;
    repeat (2) @(posedge clock);
  endtask

  task automatic chk_idle_outputs(input string tag);
    chk({tag, "_done"}, {7'd0, cpu_done}, 8'd0);
    chk({tag, "_pulses"}, {4'd0, bus_read_miss, bus_write_miss, bus_invalidate, bus_write_back}, 8'd0);
    chk({tag, "_data_out"}, {4'd0, cpu_data_out}, 8'd0);
    chk({tag, "_bus_addr"}, {5'd0, bus_address}, 8'd0);
    chk({tag, "_bus_data"}, {4'd0, bus_data_out}, 8'd0);
  endtask

  initial begin
    bit seen;
    repeat (3) @(posedge clock);
    #1;
    chk_idle_outputs("reset");
    reset = 1'b0;

    // 1: cold read miss then hit
    start_req(1'b0, 3'b010, 4'h0); push(K_RM, t0 + 3, 3'b010, 4'h0);
    wait_done(4'hA, 4'hA, -1, 2'b00, 3'b000);
    start_req(1'b0, 3'b010, 4'h0); push(K_DONE, t0 + 2, 3'b000, 4'hA);
    wait_done(4'h0, 4'h0, -1, 2'b00, 3'b000);

    // 2: write on S upgrades via invalidate, write on M is silent
    start_req(1'b1, 3'b010, 4'h5); push(K_INV, t0 + 2, 3'b010, 4'h0); push(K_DONE, t0 + 2, 3'b000, 4'hA);
    wait_done(4'h0, 4'h0, -1, 2'b00, 3'b000);
    start_req(1'b1, 3'b010, 4'h6); push(K_DONE, t0 + 2, 3'b000, 4'hA);
    wait_done(4'h0, 4'h0, -1, 2'b00, 3'b000);

    // 3: conflicting read evicts dirty victim
    start_req(1'b0, 3'b100, 4'h0); push(K_WB, t0 + 3, 3'b010, 4'h6); push(K_RM, t0 + 4, 3'b100, 4'h0);
    wait_done(4'h9, 4'h9, -1, 2'b00, 3'b000);
    start_req(1'b0, 3'b100, 4'h0); push(K_DONE, t0 + 2, 3'b000, 4'h9);
    wait_done(4'h0, 4'h0, -1, 2'b00, 3'b000);

    // 4: write miss discards fill data; snoops on line1
    start_req(1'b1, 3'b011, 4'hC); push(K_WM, t0 + 3, 3'b011, 4'h0);
    wait_done(4'h7, 4'h9, -1, 2'b00, 3'b000);
    start_req(1'b0, 3'b011, 4'h0); push(K_DONE, t0 + 2, 3'b000, 4'hC);
    wait_done(4'h0, 4'h0, -1, 2'b00, 3'b000);
    do_snoop(2'b00, 3'b011, 1'b1, 4'hC);
    do_snoop(2'b01, 3'b011, 1'b0, 4'h0);
    start_req(1'b0, 3'b011, 4'h0); push(K_RM, t0 + 3, 3'b011, 4'h0);
    wait_done(4'hD, 4'hD, -1, 2'b00, 3'b000);
    do_snoop(2'b10, 3'b111, 1'b0, 4'h0);
    do_snoop(2'b11, 3'b011, 1'b0, 4'h0);
    start_req(1'b0, 3'b011, 4'h0); push(K_DONE, t0 + 2, 3'b000, 4'hD);
    wait_done(4'h0, 4'h0, -1, 2'b00, 3'b000);

    // 5: snoop collides with LOOKUP on the same line
    start_req(1'b1, 3'b100, 4'h3); push(K_WM, t0 + 4, 3'b100, 4'h0);
    wait_done(4'h0, 4'hD, 1, 2'b10, 3'b100);
    start_req(1'b0, 3'b100, 4'h0); push(K_WB, t0 + 2, 3'b100, 4'h3); push(K_DONE, t0 + 3, 3'b000, 4'h3);
    wait_done(4'h0, 4'h0, 1, 2'b00, 3'b100);

    // 6: reset while waiting in FILL drops the request
    start_req(1'b0, 3'b001, 4'h0); push(K_RM, t0 + 3, 3'b001, 4'h0);
    seen = 0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(posedge clock); #1;
      if (bus_read_miss) seen = 1;
    end
    chk("fill_wait_miss_seen", {7'd0, seen}, 8'd1);
    cpu_req = 1'b0; reset = 1'b1;
    @(posedge clock); #1;
    reset = 1'b0; fill_valid = 1'b1; fill_data = 4'hE;
    @(posedge clock); #1;
    fill_valid = 1'b0;
    chk_idle_outputs("post_reset");
    repeat (3) @(posedge clock);
    #1;
    chk_idle_outputs("post_reset_late");
    start_req(1'b0, 3'b100, 4'h0); push(K_RM, t0 + 3, 3'b100, 4'h0);
    wait_done(4'h2, 4'h2, -1, 2'b00, 3'b000);

    repeat (3) @(posedge clock);
    chk("scoreboard_drained", 8'(q.size()), 8'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout cyc=%0d", cyc);
    $fatal(1, "timeout");
  end
endmodule

// File: doc/msi_cache_ctrl.md
Name: msi_cache_ctrl

Overview:
Parametrised direct-mapped, write-back L1 cache controller implementing the MSI snooping protocol. It serves one CPU port and snoops a shared bus. It generalises the fixed two-block CPU-side state machine to LINES lines and configurable address/data widths. It adds real tag/data storage, victim write-back, miss fill, and snoop-side state transitions.

Parameters:
ADDR_W, 3, CPU/bus address width in bits
DATA_W, 4, data word width (one word per line)
LINES, 2, number of lines; power of 2, >=2; IDX_W=log2(LINES), tag = address[ADDR_W-1:IDX_W], index = address[IDX_W-1:0]

Ports:
clock  in  1  system clock, all logic on posedge
reset  in  1  synchronous, active-high reset
cpu_req  in  1  request; held high until cpu_done
cpu_write  in  1  1=write, 0=read; sampled with cpu_req
cpu_address  in  ADDR_W  request address
cpu_data_in  in  DATA_W  write data
cpu_done  out  1  one-cycle completion pulse
cpu_data_out  out  DATA_W  read data; valid with cpu_done, then held
bus_read_miss  out  1  one-cycle pulse: read miss placed on bus
bus_write_miss  out  1  one-cycle pulse: write miss placed on bus
bus_invalidate  out  1  one-cycle pulse: upgrade S->M on bus
bus_write_back  out  1  one-cycle pulse: dirty line flushed (victim or snoop)
bus_address  out  ADDR_W  address for any bus pulse
bus_data_out  out  DATA_W  data for bus_write_back
fill_valid  in  1  memory fill response for outstanding miss
fill_data  in  DATA_W  fill word
snoop_valid  in  1  remote transaction present this cycle
snoop_type  in  2  00 read miss, 01 write miss, 10 invalidate, 11 ignored
snoop_address  in  ADDR_W  remote transaction address

Behaviour:
- Per line: state {I=00,S=01,M=10}, tag, data. Reset sets all lines I, tag 0, data 0, FSM IDLE. All outputs are 0 at reset.
- All outputs are registered. A decision made at cycle t is visible at t+1. Bus pulses are mutually exclusive in any cycle.
- Hit = line state != I and stored tag == request tag.
- FSM IDLE: if cpu_req=1, latch write/address/data, go to LOOKUP. cpu_req is ignored in every other state.
- FSM LOOKUP:
  - Read hit -> cpu_done, cpu_data_out=line data; go to IDLE.
  - Write hit, M -> line data=latched data, cpu_done; go to IDLE.
  - Write hit, S -> bus_invalidate with request address, line to M, write data, cpu_done; go to IDLE.
  - Miss with victim in M -> go to WB.
  - Miss with victim in S or I -> go to ISSUE.
- FSM WB: bus_write_back, bus_address={victim tag,index}, bus_data_out=victim data. Victim goes to I. Go to ISSUE.
- FSM ISSUE: bus_read_miss or bus_write_miss with request address; go to FILL.
- FSM FILL: wait indefinitely for fill_valid. On fill_valid, install the tag.
  - Read: line to S, data=fill_data, cpu_data_out=fill_data, cpu_done.
  - Write: line to M, data=cpu_data_in latched (fill_data discarded), cpu_done.
  - Go to IDLE. fill_valid outside FILL is ignored.
- Latency from cpu_req sampled in IDLE at cycle t: hit -> cpu_done at t+2. Clean miss -> bus miss pulse at t+3, cpu_done one cycle after fill_valid. Dirty miss -> write-back at t+3, miss at t+4.
- Snoop, processed every cycle on line[snoop index], only if that line hits snoop tag:
  - Read miss on M -> bus_write_back (snoop address, line data), line to S.
  - Write miss on M -> bus_write_back, line to I.
  - Write miss on S -> line to I.
  - Invalidate on S or M -> line to I, no flush.
  - All other combinations: no action.
- Collisions (snoop wins):
  - Snoop hitting any line while FSM is in LOOKUP or WB stalls the FSM one cycle; the state is re-evaluated next cycle with the updated line.
  - A snoop write-back and an FSM write-back never share a cycle.
- Own transactions are never snooped back.
- Reset mid-operation (any state, including FILL): immediate return to reset values. The pending request is dropped; the CPU must reassert. A later fill_valid is ignored.

Test Plan:
1. Reset, read 3'b010 -> bus_read_miss, bus_address=010 at t+3; fill_data=4'hA -> cpu_done, cpu_data_out=A, line0=S; repeat read -> hit, cpu_done at t+2, no bus pulse.
2. Write 3'b010 data 5 on S line -> bus_invalidate addr 010, cpu_done at t+2, line0=M data 5; second write of 6 -> no bus pulse.
3. Line0 M tag01 data 6, read 3'b100 -> bus_write_back addr 010 data 6, then bus_read_miss addr 100, fill 9 -> cpu_data_out=9, line0=S tag10.
4. Line1 M (addr 011, data C), snoop read miss 011 -> bus_write_back addr 011 data C next cycle, line1=S; snoop write miss 011 -> line1=I, no flush.
5. Snoop hit on line0 in same cycle FSM is in LOOKUP for line0 -> FSM stalls one cycle; cpu_done delayed to t+3 with post-snoop outcome (e.g. S line invalidated turns write hit into write miss).
6. Reset asserted in FILL, then fill_valid=1 -> no cpu_done, all lines I, all outputs 0.
